// File: rtl/parallel_to_serial.sv
// Parallel-to-serial transmitter: captures a BUS_WIDTH word on load and shifts it out LSB first,
// with a hold input that freezes shifting and a one-cycle done pulse after the last bit.
module parallel_to_serial #(
  parameter int unsigned BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 hold,
  output logic                 data_out,
  output logic                 data_valid,
  output logic                 ready,
  output logic                 done
);

  localparam int unsigned CntW = $clog2(BUS_WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BUS_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shift_d = data_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (!hold) begin
          shift_d = {1'b0, shift_q[BUS_WIDTH-1:1]};
          // The edge that would bring the count to BUS_WIDTH ends the transfer instead.
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    data_out   = 1'b0;
    data_valid = 1'b0;
    ready      = (state_q == StIdle);
    done       = (state_q == StDone);
    if (state_q == StShift) begin
      data_out   = shift_q[0];
      data_valid = !hold;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: 16-bit and 8-bit instances checked against a bit-stream
// receiver model and a cycle-count model of hold and latency.
module tb_parallel_to_serial;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        load16, load8;
  logic [15:0] din16;
  logic [7:0]  din8;
  logic        dout16, dv16, rdy16, done16;
  logic        dout8, dv8, rdy8, done8;

  int checks;
  int errors;

  parallel_to_serial #(.BUS_WIDTH(16)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .load       (load16),
    .data_in    (din16),
    .hold       (hold),
    .data_out   (dout16),
    .data_valid (dv16),
    .ready      (rdy16),
    .done       (done16)
  );

  parallel_to_serial #(.BUS_WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .load       (load8),
    .data_in    (din8),
    .hold       (hold),
    .data_out   (dout8),
    .data_valid (dv8),
    .ready      (rdy8),
    .done       (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle (counted from the accepting edge) in which done is expected: every SHIFT cycle
  // without hold delivers one bit, done follows the cycle carrying the last bit.
  function automatic int exp_done(input int w, input logic [63:0] hm);
    int c;
    int v;
    c = 1;
    v = 0;
    while (v < w) begin
      if (!(c < 64 && hm[c])) v++;
      c++;
    end
    return c;
  endfunction

  // Drives one transfer and records what a receiver on the same clock would see.
  task automatic xfer(input bit w8, input logic [15:0] word, input logic [63:0] hm,
                      input int gl_cyc, input logic [15:0] gl_data,
                      output logic [15:0] rx, output int nvalid, output int done_cyc,
                      output int ready_cyc, output int stray);
    int  guard;
    logic dv, dout, dn, rd;
    rx = '0; nvalid = 0; done_cyc = -1; ready_cyc = -1; stray = 0; guard = 0;
    while (!(w8 ? rdy8 : rdy16) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (w8) begin load8 = 1'b1; din8 = word[7:0]; end
    else begin load16 = 1'b1; din16 = word; end
    @(posedge clk); #1;
    load8 = 1'b0; load16 = 1'b0;
    din8 = 8'($urandom); din16 = 16'($urandom);
    for (int c = 1; c < 200; c++) begin
      hold = (c < 64) ? hm[c] : 1'b0;
      if (c == gl_cyc) begin
        if (w8) begin load8 = 1'b1; din8 = gl_data[7:0]; end
        else begin load16 = 1'b1; din16 = gl_data; end
      end else begin
        load8 = 1'b0; load16 = 1'b0;
      end
      @(negedge clk);
      dv = w8 ? dv8 : dv16;
      dout = w8 ? dout8 : dout16;
      dn = w8 ? done8 : done16;
      rd = w8 ? rdy8 : rdy16;
      if (dv) begin
        if (nvalid < 16) rx[nvalid] = dout;
        nvalid++;
      end
      if ((dn || rd) && (dout || dv)) stray++;
      if (dn && done_cyc < 0) done_cyc = c;
      if (rd) begin
        ready_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    hold = 1'b0; load8 = 1'b0; load16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (rdy16 !== 1'b1 || dv16 !== 1'b0 || dout16 !== 1'b0 || done16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: rdy=%b dv=%b dout=%b done=%b, required 1 0 0 0",
               rdy16, dv16, dout16, done16);
    end
    checks++;
    if (rdy8 !== 1'b1 || dv8 !== 1'b0 || dout8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: rdy=%b dv=%b dout=%b done=%b, required 1 0 0 0",
               rdy8, dv8, dout8, done8);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] rx;
    int nv, dc, rc, st;
    xfer(1'b0, 16'hA5C3, 64'd0, -1, 16'h0, rx, nv, dc, rc, st);
    checks++;
    if (rx !== 16'hA5C3 || nv != 16) begin
      errors++;
      $display("FAIL basic_data: got %h/%0d bits, required a5c3/16", rx, nv);
    end
    checks++;
    if (dc != 17 || rc != 18 || st != 0) begin
      errors++;
      $display("FAIL basic_timing: done %0d ready %0d stray %0d, required 17 18 0", dc, rc, st);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [4];
    logic [15:0] rx;
    int nv, dc, rc, st;
    words = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
    foreach (words[i]) begin
      xfer(1'b0, words[i], 64'd0, -1, 16'h0, rx, nv, dc, rc, st);
      checks++;
      if (rx !== words[i] || nv != 16 || dc != 17 || rc != 18 || st != 0) begin
        errors++;
        $display("FAIL loopback[%0d]: got %h/%0d done %0d ready %0d, required %h/16 17 18",
                 i, rx, nv, dc, rc, words[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [63:0] hm;
    logic [15:0] rx, w;
    int nv, dc, rc, st;
    hm = '0;
    hm[6] = 1'b1; hm[7] = 1'b1; hm[8] = 1'b1;
    hm[19] = 1'b1; hm[20] = 1'b1;
    w = 16'h5A3C;
    xfer(1'b0, w, hm, -1, 16'h0, rx, nv, dc, rc, st);
    checks++;
    if (rx !== w || nv != 16) begin
      errors++;
      $display("FAIL hold_data: got %h/%0d bits, required %h/16", rx, nv, w);
    end
    checks++;
    if (dc != 22 || rc != 23) begin
      errors++;
      $display("FAIL hold_timing: done %0d ready %0d, required 22 23", dc, rc);
    end
  endtask

  task automatic test_ignored_load();
    logic [15:0] rx;
    int nv, dc, rc, st, busy;
    xfer(1'b0, 16'h3C96, 64'd0, 5, 16'hFFFF, rx, nv, dc, rc, st);
    checks++;
    if (rx !== 16'h3C96 || nv != 16 || dc != 17) begin
      errors++;
      $display("FAIL load_in_shift: got %h/%0d done %0d, required 3c96/16 17", rx, nv, dc);
    end
    xfer(1'b0, 16'hC003, 64'd0, 17, 16'h7777, rx, nv, dc, rc, st);
    checks++;
    if (rx !== 16'hC003 || nv != 16 || dc != 17) begin
      errors++;
      $display("FAIL load_in_done: got %h/%0d done %0d, required c003/16 17", rx, nv, dc);
    end
    busy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dv16 || !rdy16) busy++;
    end
    checks++;
    if (busy != 0) begin
      errors++;
      $display("FAIL no_extra_transfer: busy cycles %0d, required 0", busy);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] w, rx;
    logic pre_dv, pre_dout;
    int nv, dc, rc, st, bad;
    w = 16'h0F80;
    @(negedge clk);
    load16 = 1'b1; din16 = w;
    @(posedge clk); #1;
    load16 = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    pre_dv = dv16; pre_dout = dout16;
    checks++;
    if (pre_dv !== 1'b1 || pre_dout !== w[7]) begin
      errors++;
      $display("FAIL pre_reset_bit7: dv %b dout %b, required 1 %b", pre_dv, pre_dout, w[7]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dv16 !== 1'b0 || dout16 !== 1'b0 || done16 !== 1'b0 || rdy16 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: dv %b dout %b done %b rdy %b, required 0 0 0 1",
               dv16, dout16, done16, rdy16);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done16 || !rdy16 || dv16) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_abort: non-idle cycles %0d, required 0", bad);
    end
    xfer(1'b0, 16'h00FF, 64'd0, -1, 16'h0, rx, nv, dc, rc, st);
    checks++;
    if (rx !== 16'h00FF || nv != 16 || dc != 17 || rc != 18) begin
      errors++;
      $display("FAIL after_reset: got %h/%0d done %0d ready %0d, required 00ff/16 17 18",
               rx, nv, dc, rc);
    end
  endtask

  task automatic test_width8();
    logic [15:0] rx;
    int nv, dc, rc, st;
    xfer(1'b1, 16'h0096, 64'd0, -1, 16'h0, rx, nv, dc, rc, st);
    checks++;
    if (rx !== 16'h0096 || nv != 8) begin
      errors++;
      $display("FAIL width8_data: got %h/%0d bits, required 0096/8", rx, nv);
    end
    checks++;
    if (dc != 9 || rc != 10 || st != 0) begin
      errors++;
      $display("FAIL width8_timing: done %0d ready %0d stray %0d, required 9 10 0", dc, rc, st);
    end
  endtask

  task automatic test_random();
    logic [15:0] word, rx, gd;
    logic [63:0] hm;
    bit w8;
    int w, ed, gl, nv, dc, rc, st;
    for (int i = 0; i < 24; i++) begin
      w8 = 1'($urandom_range(0, 1));
      w = w8 ? 8 : 16;
      word = 16'($urandom);
      if (w8) word[15:8] = 8'h00;
      hm = '0;
      for (int c = 1; c < 40; c++) if ($urandom_range(0, 3) == 0) hm[c] = 1'b1;
      ed = exp_done(w, hm);
      gl = int'($urandom_range(1, ed));
      gd = 16'($urandom);
      xfer(w8, word, hm, gl, gd, rx, nv, dc, rc, st);
      checks++;
      if (rx !== word || nv != w || dc != ed || rc != ed + 1 || st != 0) begin
        errors++;
        $display("FAIL random[%0d] w%0d: got %h/%0d done %0d ready %0d stray %0d, required %h/%0d %0d %0d 0",
                 i, w, rx, nv, dc, rc, st, word, w, ed, ed + 1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hold = 1'b0;
    load16 = 1'b0;
    load8 = 1'b0;
    din16 = '0;
    din8 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_ignored_load();
    test_async_reset();
    test_width8();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
